// File: rtl/lvds_pattern_pkg.sv
// Shared types and constants for the LVDS test-pattern transmitter.
package lvds_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_PRBS7   = 2'd2,
    MODE_PATTERN = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // x^7 + x^6 + 1: feedback taps are state bits 6 and 5
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  // One LFSR step; the freshly generated bit lands in bit 0 and is the output bit.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/lvds_pattern_core.sv
// Pattern engine: tick divider, enable FSM with warm-up, four pattern
// generators and the pattern-word handshake. Produces one DDR bit pair per
// channel plus a shared output-enable (active low, 1 = pads tri-stated).
module lvds_pattern_core
  import lvds_pattern_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int DIV_WIDTH     = 25,
  parameter int PATTERN_WIDTH = 8,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              key,
  input  logic [1:0]                        mode,
  input  logic [DIV_WIDTH-1:0]              div_value,
  input  logic [CHANNELS*PATTERN_WIDTH-1:0] pat_data,
  input  logic                              pat_valid,
  output logic                              pat_ready,
  output logic [CHANNELS-1:0]               d0,
  output logic [CHANNELS-1:0]               d1,
  output logic                              oen,
  output logic                              running,
  output logic                              underrun
);

  localparam int PAT_TICKS = PATTERN_WIDTH / 2;
  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int LW = (PAT_TICKS > 1) ? $clog2(PAT_TICKS) : 1;
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [LW-1:0] PAT_LAST  = LW'(PAT_TICKS - 1);

  state_t               state;
  state_t               state_next;
  logic [WW-1:0]        warm_cnt;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;
  logic                 gen_tick;
  mode_t                mode_in;
  mode_t                mode_q;
  logic                 tog_q;
  logic [6:0]           prbs_q;
  logic [6:0]           prbs_s1;
  logic [6:0]           prbs_s2;
  logic [LW-1:0]        pat_left;
  logic                 need_load;
  logic                 pat_load_tick;
  logic                 xfer;

  assign mode_in = mode_t'(mode);

  // A tick only exists while the transmitter is enabled; generators advance
  // only if the enable is not being withdrawn in the same cycle.
  assign tick     = (state != ST_OFF) && (div_cnt == div_value);
  assign gen_tick = tick && key;

  // A PATTERN tick needs a fresh word when the current one is spent, or when
  // the previous tick was in some other mode.
  assign need_load     = (mode_q != MODE_PATTERN) || (pat_left == '0);
  assign pat_load_tick = gen_tick && (mode_in == MODE_PATTERN) && need_load;
  assign pat_ready     = (state != ST_OFF) &&
                         ((mode_in == MODE_STATIC) || pat_load_tick);
  assign xfer          = pat_valid && pat_ready;

  assign prbs_s1 = prbs7_step(prbs_q);
  assign prbs_s2 = prbs7_step(prbs_s1);

  assign oen     = (state != ST_RUN);
  assign running = (state == ST_RUN);

  // Enable FSM next state; dropping key forces OFF from anywhere.
  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:    if (key) state_next = ST_WARMUP;
      ST_WARMUP: if (warm_cnt == WARM_LAST) state_next = ST_RUN;
      ST_RUN:    state_next = ST_RUN;
      default:   state_next = ST_OFF;
    endcase
    if (!key) state_next = ST_OFF;
  end

  // FSM state register and warm-up cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      warm_cnt <= '0;
    end else begin
      state <= state_next;
      if (state != ST_WARMUP) warm_cnt <= '0;
      else                    warm_cnt <= warm_cnt + WW'(1);
    end
  end

  // Tick divider: parked at 0 while OFF or about to be OFF, free-running
  // otherwise. Lowering div_value below the count lets it wrap through zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if ((state == ST_OFF) || (state_next == ST_OFF) || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // Channel-shared generator state: sampled mode, toggle phase, LFSR,
  // pattern word progress and the sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_STATIC;
      tog_q    <= 1'b0;
      prbs_q   <= PRBS7_SEED;
      pat_left <= '0;
      underrun <= 1'b0;
    end else if (gen_tick) begin
      mode_q <= mode_in;
      case (mode_in)
        MODE_TOGGLE: tog_q  <= ~tog_q;
        MODE_PRBS7:  prbs_q <= prbs_s2;
        MODE_PATTERN: begin
          if (need_load) begin
            pat_left <= PAT_LAST;
            if (!pat_valid) underrun <= 1'b1;
          end else begin
            pat_left <= pat_left - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic PHASE = 1'((gi % 2));

    logic [PATTERN_WIDTH-1:0] word_in;
    logic [PATTERN_WIDTH-1:0] word_q;
    logic [PATTERN_WIDTH-1:0] load_word;
    logic [PATTERN_WIDTH-1:0] sr_q;
    logic                     d0_q;
    logic                     d1_q;
    logic                     d0_tick;
    logic                     d1_tick;

    assign word_in   = pat_data[gi*PATTERN_WIDTH +: PATTERN_WIDTH];
    // A word accepted this cycle is used immediately; otherwise the last one.
    assign load_word = xfer ? word_in : word_q;

    // Bit pair this channel would present if the current cycle is a tick.
    always_comb begin
      d0_tick = 1'b0;
      d1_tick = 1'b0;
      case (mode_in)
        MODE_STATIC: begin
          d0_tick = load_word[0];
          d1_tick = load_word[0];
        end
        MODE_TOGGLE: begin
          d0_tick = ~tog_q ^ PHASE;
          d1_tick = ~tog_q ^ PHASE;
        end
        MODE_PRBS7: begin
          d0_tick = prbs_s1[0];
          d1_tick = prbs_s2[0];
        end
        MODE_PATTERN: begin
          d0_tick = need_load ? load_word[0] : sr_q[0];
          d1_tick = need_load ? load_word[1] : sr_q[1];
        end
        default: ;
      endcase
    end

    // Per-channel word store, shift register and held output pair.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
        sr_q   <= '0;
        d0_q   <= 1'b0;
        d1_q   <= 1'b0;
      end else begin
        if (xfer) word_q <= word_in;
        if (gen_tick && (mode_in == MODE_PATTERN))
          sr_q <= (need_load ? load_word : sr_q) >> 2;
        if (state_next == ST_OFF) begin
          d0_q <= 1'b0;
          d1_q <= 1'b0;
        end else if (gen_tick) begin
          d0_q <= d0_tick;
          d1_q <= d1_tick;
        end
      end
    end

    assign d0[gi] = d0_q;
    assign d1[gi] = d1_q;
  end

endmodule

// File: rtl/lvds_pattern_tx.sv
// Multi-channel LVDS test-pattern transmitter: pattern core followed by a
// DDR output stage and tri-stateable differential pad pair per channel.
module lvds_pattern_tx
  import lvds_pattern_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int DIV_WIDTH     = 25,
  parameter int PATTERN_WIDTH = 8,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              key,
  input  logic [1:0]                        mode,
  input  logic [DIV_WIDTH-1:0]              div_value,
  input  logic [CHANNELS*PATTERN_WIDTH-1:0] pat_data,
  input  logic                              pat_valid,
  output logic                              pat_ready,
  output logic [CHANNELS-1:0]               tlvds_p,
  output logic [CHANNELS-1:0]               tlvds_n,
  output logic                              running,
  output logic                              underrun
);

  logic [CHANNELS-1:0] d0;
  logic [CHANNELS-1:0] d1;
  logic                oen;
  logic [CHANNELS-1:0] ddr_q;

  lvds_pattern_core #(
    .CHANNELS      (CHANNELS),
    .DIV_WIDTH     (DIV_WIDTH),
    .PATTERN_WIDTH (PATTERN_WIDTH),
    .WARMUP_CYCLES (WARMUP_CYCLES)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .mode      (mode),
    .div_value (div_value),
    .pat_data  (pat_data),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .d0        (d0),
    .d1        (d1),
    .oen       (oen),
    .running   (running),
    .underrun  (underrun)
  );

  // Portable DDR output stage standing in for the vendor ODDR: both halves
  // are captured on the rising edge, d0 is sent in the high phase and d1 in
  // the low phase, so the pad follows the core pair one clk later.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pad
    logic d0_q;
    logic d1_q;

    // Capture the pair for the next DDR bit period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d0_q <= 1'b0;
        d1_q <= 1'b0;
      end else begin
        d0_q <= d0[gi];
        d1_q <= d1[gi];
      end
    end

    assign ddr_q[gi] = clk ? d0_q : d1_q;
  end

  // Differential tri-state pad buffers; the shared enable comes straight from
  // the core's async-reset state so reset releases the pads immediately.
  assign tlvds_p = oen ? {CHANNELS{1'bz}} : ddr_q;
  assign tlvds_n = oen ? {CHANNELS{1'bz}} : ~ddr_q;

endmodule
